mips_exec_core: RTL and testbench
=================================

Name: mips_exec_core

Overview:
- Decode/execute/writeback datapath of the single-issue MIPS lab CPU.
- Takes the current 32-bit instruction from the fetch stage. Decodes it (control unit), reads a 32x32 register file, and computes in a 32-bit ALU with HI/LO support.
- Writes the result back one pipeline stage later and drives the GPIO port.
- PC/fetch logic lives outside this block.

Parameters:
- none (widths fixed: 32-bit data, 5-bit register addresses)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-low reset
- instruction_EX  in  32  instruction in execute stage this cycle
- gpio_in  in  32  GPIO input word
- gpio_out  out  32  registered GPIO output word
- alu_lo  out  32  combinational ALU low result (debug)
- zero  out  1  combinational: alu_lo == 0

Behaviour:
- Reset (rst=0 at posedge) clears:
  - all 32 registers, HI, LO and gpio_out (to 0);
  - WB regwrite.
- Decode fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0].
- R-type (opcode 0), write rd:
  - Arithmetic/logic: add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2a, sltu 0x2b.
  - Shifts of rt by shamt: sll 0x00, srl 0x02, sra 0x03.
  - HI/LO reads: mfhi 0x10 writes HI to rd; mflo 0x12 writes LO to rd.
  - mult 0x18 / multu 0x19: {HI,LO} <= 64-bit rs*rt, signed/unsigned. No GPR write.
- I-type, write rt:
  - Sign-extended immediate: addi 0x08, addiu 0x09, slti 0x0a, sltiu 0x0b.
  - Zero-extended immediate: andi 0x0c, ori 0x0d, xori 0x0e.
  - lui 0x0f: {imm,16'h0}.
- GPIO:
  - opcode 0x23 (lw slot): rt <= gpio_in.
  - opcode 0x2b (sw slot): gpio_out <= rt value at the end of the EX cycle.
- Arithmetic rules:
  - add and addu behave identically; sub and subu behave identically; no overflow traps.
  - slt/slti compare signed; sltu/sltiu compare unsigned.
  - sra is arithmetic.
- Any other opcode or funct is a NOP: no GPR, HI/LO or GPIO update.
- Timing:
  - EX is combinational (decode, regfile read, ALU).
  - At the posedge ending EX, the WB register captures writedata, writeaddr and regwrite. HI/LO and gpio_out update at that same edge.
  - The regfile is written at the following posedge.
- Hazards:
  - The regfile read is write-through: if we && writeaddr==readaddr && addr!=0, the read returns writedata. This makes back-to-back dependencies correct with no stall.
  - mfhi/mflo immediately after mult sees the new HI/LO.
- Register $0:
  - always reads 0;
  - writes to it are discarded, including through the bypass.
- Reset asserted mid-stream: a pending WB write is dropped.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct localparams;
  - a 4-bit alu_op_t enum: AND, OR, XOR, NOR, ADD, SUB, MULT, MULTU, SLT, SLTU, SLL, SRL, SRA, LUI;
  - wbsel_t: ALU, HI, LO, GPIO.
- Sub-modules: control_unit (pure combinational decode), reg_file, and alu (hi/lo/zero outputs).
- The top holds the muxes, WB register, HI/LO registers and gpio_out.

Test Plan:
- Reset: hold rst=0 two cycles with random instructions -> gpio_out=0. Then 0xAC010000 (sw $1) -> gpio_out=0.
- Arithmetic plus forwarding, back to back:
  - 0x20010005 (addi $1,$0,5)
  - 0x2002FFFD (addi $2,$0,-3)
  - 0x00221820 (add $3,$1,$2)
  - 0xAC030000
  - -> gpio_out=0x00000002 one cycle after the sw.
- GPIO in: gpio_in=0xDEADBEEF; 0x8C040000 then 0xAC040000 -> gpio_out=0xDEADBEEF.
- Multiply:
  - 0x3C010001, 0x3C020001 (lui), 0x00220018 (mult)
  - 0x00002810 (mfhi $5), 0xAC050000 -> gpio_out=1
  - then 0x00003012 (mflo $6), 0xAC060000 -> 0
- Shifts and compares, with $1=-8 (0x2001FFF8):
  - sra $7,$1,1 -> 0xFFFFFFFC
  - srl -> 0x7FFFFFFC
  - slt $8,$1,$0 -> 1
  - sltu -> 0
- $0 and NOP: 0x20000007 (addi $0,$0,7) then 0xAC000000 -> gpio_out=0. Opcode 0x3F leaves all state unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute core: opcode/funct values, ALU op and
// writeback-select enums, and the decoded control bundle.
package mips_pkg;
   localparam logic [5:0] OP_RTYPE   = 6'h00;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0a;
   localparam logic [5:0] OP_SLTIU   = 6'h0b;
   localparam logic [5:0] OP_ANDI    = 6'h0c;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_XORI    = 6'h0e;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_GPIO_RD = 6'h23;
   localparam logic [5:0] OP_GPIO_WR = 6'h2b;

   localparam logic [5:0] F_SLL   = 6'h00;
   localparam logic [5:0] F_SRL   = 6'h02;
   localparam logic [5:0] F_SRA   = 6'h03;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_ADDU  = 6'h21;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_SUBU  = 6'h23;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_XOR   = 6'h26;
   localparam logic [5:0] F_NOR   = 6'h27;
   localparam logic [5:0] F_SLT   = 6'h2a;
   localparam logic [5:0] F_SLTU  = 6'h2b;

   typedef enum logic [3:0] {
      ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_ADD, ALU_SUB, ALU_MULT, ALU_MULTU,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
   } alu_op_t;

   typedef enum logic [1:0] {WB_ALU, WB_HI, WB_LO, WB_GPIO} wbsel_t;

   typedef struct packed {
      alu_op_t alu_op;
      logic    use_imm;
      logic    imm_zext;
      logic    regwrite;
      logic    dst_rd;
      wbsel_t  wbsel;
      logic    hilo_we;
      logic    gpio_we;
   } ctrl_t;
endpackage

// File: rtl/alu.sv
// 32-bit ALU; multiplies return the full 64-bit product split across hi/lo.
module alu
   import mips_pkg::*;
(
   input  alu_op_t     op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [4:0]  shamt_i,
   output logic [31:0] lo_o,
   output logic [31:0] hi_o,
   output logic        zero_o
);
   logic [63:0] prod_s, prod_u;

   // Low 64 bits of a product of sign-extended operands equal the signed product.
   assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
   assign prod_u = {32'd0, a_i} * {32'd0, b_i};

   always_comb begin
      lo_o = '0;
      hi_o = '0;
      case (op_i)
         ALU_AND:   lo_o = a_i & b_i;
         ALU_OR:    lo_o = a_i | b_i;
         ALU_XOR:   lo_o = a_i ^ b_i;
         ALU_NOR:   lo_o = ~(a_i | b_i);
         ALU_ADD:   lo_o = a_i + b_i;
         ALU_SUB:   lo_o = a_i - b_i;
         ALU_MULT:  {hi_o, lo_o} = prod_s;
         ALU_MULTU: {hi_o, lo_o} = prod_u;
         ALU_SLT:   lo_o = {31'd0, $signed(a_i) < $signed(b_i)};
         ALU_SLTU:  lo_o = {31'd0, a_i < b_i};
         ALU_SLL:   lo_o = b_i << shamt_i;
         ALU_SRL:   lo_o = b_i >> shamt_i;
         ALU_SRA:   lo_o = $signed(b_i) >>> shamt_i;
         ALU_LUI:   lo_o = {b_i[15:0], 16'h0000};
         default:   lo_o = '0;
      endcase
   end

   assign zero_o = (lo_o == 32'd0);
endmodule

// File: rtl/control_unit.sv
// Pure combinational decode of opcode/funct into the control bundle.
module control_unit
   import mips_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output ctrl_t      ctrl_o
);
   always_comb begin
      ctrl_o = '0;
      case (opcode_i)
         OP_RTYPE: begin
            ctrl_o.dst_rd   = 1'b1;
            ctrl_o.regwrite = 1'b1;
            case (funct_i)
               F_ADD, F_ADDU: ctrl_o.alu_op = ALU_ADD;
               F_SUB, F_SUBU: ctrl_o.alu_op = ALU_SUB;
               F_AND:         ctrl_o.alu_op = ALU_AND;
               F_OR:          ctrl_o.alu_op = ALU_OR;
               F_XOR:         ctrl_o.alu_op = ALU_XOR;
               F_NOR:         ctrl_o.alu_op = ALU_NOR;
               F_SLT:         ctrl_o.alu_op = ALU_SLT;
               F_SLTU:        ctrl_o.alu_op = ALU_SLTU;
               F_SLL:         ctrl_o.alu_op = ALU_SLL;
               F_SRL:         ctrl_o.alu_op = ALU_SRL;
               F_SRA:         ctrl_o.alu_op = ALU_SRA;
               F_MFHI:        ctrl_o.wbsel  = WB_HI;
               F_MFLO:        ctrl_o.wbsel  = WB_LO;
               F_MULT: begin
                  ctrl_o.regwrite = 1'b0;
                  ctrl_o.hilo_we  = 1'b1;
                  ctrl_o.alu_op   = ALU_MULT;
               end
               F_MULTU: begin
                  ctrl_o.regwrite = 1'b0;
                  ctrl_o.hilo_we  = 1'b1;
                  ctrl_o.alu_op   = ALU_MULTU;
               end
               default: ctrl_o.regwrite = 1'b0;
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            ctrl_o.regwrite = 1'b1; ctrl_o.use_imm = 1'b1; ctrl_o.alu_op = ALU_ADD;
         end
         OP_SLTI: begin
            ctrl_o.regwrite = 1'b1; ctrl_o.use_imm = 1'b1; ctrl_o.alu_op = ALU_SLT;
         end
         OP_SLTIU: begin
            ctrl_o.regwrite = 1'b1; ctrl_o.use_imm = 1'b1; ctrl_o.alu_op = ALU_SLTU;
         end
         OP_ANDI: begin
            ctrl_o.regwrite = 1'b1; ctrl_o.use_imm = 1'b1; ctrl_o.imm_zext = 1'b1;
            ctrl_o.alu_op   = ALU_AND;
         end
         OP_ORI: begin
            ctrl_o.regwrite = 1'b1; ctrl_o.use_imm = 1'b1; ctrl_o.imm_zext = 1'b1;
            ctrl_o.alu_op   = ALU_OR;
         end
         OP_XORI: begin
            ctrl_o.regwrite = 1'b1; ctrl_o.use_imm = 1'b1; ctrl_o.imm_zext = 1'b1;
            ctrl_o.alu_op   = ALU_XOR;
         end
         OP_LUI: begin
            ctrl_o.regwrite = 1'b1; ctrl_o.use_imm = 1'b1; ctrl_o.alu_op = ALU_LUI;
         end
         OP_GPIO_RD: begin
            ctrl_o.regwrite = 1'b1; ctrl_o.wbsel = WB_GPIO;
         end
         OP_GPIO_WR: ctrl_o.gpio_we = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: rtl/reg_file.sv
// 32x32 register file, two read ports with write-through bypass; $0 is hardwired zero.
module reg_file (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [4:0]  raddr1_i,
   input  logic [4:0]  raddr2_i,
   output logic [31:0] rdata1_o,
   output logic [31:0] rdata2_o,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i
);
   logic [31:0] regs_q [32];

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (we_i && waddr_i != 5'd0) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   // Bypass lets the instruction right behind a writer see its result without a stall.
   always_comb begin
      rdata1_o = '0;
      rdata2_o = '0;
      if (raddr1_i != 5'd0)
         rdata1_o = (we_i && waddr_i == raddr1_i) ? wdata_i : regs_q[raddr1_i];
      if (raddr2_i != 5'd0)
         rdata2_o = (we_i && waddr_i == raddr2_i) ? wdata_i : regs_q[raddr2_i];
   end
endmodule

// File: rtl/mips_exec_core.sv
// Decode/execute/writeback datapath: combinational EX, one WB register stage,
// HI/LO and GPIO output registers.
module mips_exec_core
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction_EX,
   input  logic [31:0] gpio_in,
   output logic [31:0] gpio_out,
   output logic [31:0] alu_lo,
   output logic        zero
);
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   ctrl_t       ctrl;
   logic [31:0] rs_val, rt_val, imm_ext, alu_b, alu_hi;
   logic        wb_we_q, wb_we_d;
   logic [4:0]  wb_addr_q, wb_addr_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic [31:0] hi_q, lo_q, gpio_q;

   assign rs    = instruction_EX[25:21];
   assign rt    = instruction_EX[20:16];
   assign rd    = instruction_EX[15:11];
   assign shamt = instruction_EX[10:6];
   assign imm   = instruction_EX[15:0];

   control_unit u_ctrl (
      .opcode_i (instruction_EX[31:26]),
      .funct_i  (instruction_EX[5:0]),
      .ctrl_o   (ctrl)
   );

   reg_file u_rf (
      .clk_i    (clk),
      .rst_n_i  (rst),
      .raddr1_i (rs),
      .raddr2_i (rt),
      .rdata1_o (rs_val),
      .rdata2_o (rt_val),
      .we_i     (wb_we_q),
      .waddr_i  (wb_addr_q),
      .wdata_i  (wb_data_q)
   );

   assign imm_ext = ctrl.imm_zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
   assign alu_b   = ctrl.use_imm ? imm_ext : rt_val;

   alu u_alu (
      .op_i    (ctrl.alu_op),
      .a_i     (rs_val),
      .b_i     (alu_b),
      .shamt_i (shamt),
      .lo_o    (alu_lo),
      .hi_o    (alu_hi),
      .zero_o  (zero)
   );

   always_comb begin
      case (ctrl.wbsel)
         WB_HI:   wb_data_d = hi_q;
         WB_LO:   wb_data_d = lo_q;
         WB_GPIO: wb_data_d = gpio_in;
         default: wb_data_d = alu_lo;
      endcase
      wb_addr_d = ctrl.dst_rd ? rd : rt;
      wb_we_d   = ctrl.regwrite;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_we_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         gpio_q    <= '0;
      end else begin
         wb_we_q   <= wb_we_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         if (ctrl.hilo_we) begin
            hi_q <= alu_hi;
            lo_q <= alu_lo;
         end
         if (ctrl.gpio_we) gpio_q <= rt_val;
      end
   end

   assign gpio_out = gpio_q;
endmodule

// File: tb/tb_mips_exec_core.sv
// Randomized plus directed bench for mips_exec_core against a sequential ISA model.
module tb_mips_exec_core;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instruction_EX, gpio_in;
   logic [31:0] gpio_out, alu_lo;
   logic        zero;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_r [32];
   logic [31:0] m_hi, m_lo, m_gpio;

   mips_exec_core dut (
      .clk            (clk),
      .rst            (rst),
      .instruction_EX (instruction_EX),
      .gpio_in        (gpio_in),
      .gpio_out       (gpio_out),
      .alu_lo         (alu_lo),
      .zero           (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_r[i] = '0;
      m_hi = '0; m_lo = '0; m_gpio = '0;
   endtask

   // Architectural effect of one instruction; alu_exp is valid when has_alu is set.
   task automatic model_exec(input logic [31:0] ins, input logic [31:0] gin,
                             output bit has_alu, output logic [31:0] alu_exp);
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd, sh;
      logic [31:0] a, b, sx, zx, res;
      bit          wr, to_rd;
      longint      sp;
      longint unsigned up;
      op = ins[31:26]; fn = ins[5:0];
      rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
      a = m_r[rs]; b = m_r[rt];
      sx = {{16{ins[15]}}, ins[15:0]};
      zx = {16'h0, ins[15:0]};
      res = '0; wr = 0; to_rd = 0; has_alu = 0; alu_exp = '0;
      if (op == 6'h00) begin
         to_rd = 1; wr = 1; has_alu = 1;
         case (fn)
            6'h20, 6'h21: res = a + b;
            6'h22, 6'h23: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h26: res = a ^ b;
            6'h27: res = ~(a | b);
            6'h2a: res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6'h2b: res = (a < b) ? 32'd1 : 32'd0;
            6'h00: res = b << sh;
            6'h02: res = b >> sh;
            6'h03: res = $signed(b) >>> sh;
            6'h10: begin res = m_hi; has_alu = 0; end
            6'h12: begin res = m_lo; has_alu = 0; end
            6'h18: begin
               sp = longint'(int'(a)) * longint'(int'(b));
               {m_hi, m_lo} = sp; wr = 0; res = m_lo;
            end
            6'h19: begin
               up = longint'({32'd0, a}) * longint'({32'd0, b});
               {m_hi, m_lo} = up; wr = 0; res = m_lo;
            end
            default: begin wr = 0; has_alu = 0; end
         endcase
      end else begin
         wr = 1; has_alu = 1;
         case (op)
            6'h08, 6'h09: res = a + sx;
            6'h0a: res = (int'(a) < int'(sx)) ? 32'd1 : 32'd0;
            6'h0b: res = (a < sx) ? 32'd1 : 32'd0;
            6'h0c: res = a & zx;
            6'h0d: res = a | zx;
            6'h0e: res = a ^ zx;
            6'h0f: res = {ins[15:0], 16'h0};
            6'h23: begin res = gin; has_alu = 0; end
            6'h2b: begin m_gpio = b; wr = 0; has_alu = 0; end
            default: begin wr = 0; has_alu = 0; end
         endcase
      end
      alu_exp = res;
      if (wr && (to_rd ? rd : rt) != 5'd0) m_r[to_rd ? rd : rt] = res;
   endtask

   task automatic step(input logic [31:0] ins, input logic [31:0] gin);
      bit          ca;
      logic [31:0] ae;
      instruction_EX = ins;
      gpio_in        = gin;
      #1;
      model_exec(ins, gin, ca, ae);
      if (ca) begin
         chk($sformatf("alu_lo[%08h]", ins), alu_lo, ae);
         chk($sformatf("zero[%08h]", ins), {31'd0, zero}, {31'd0, ae == 32'd0});
      end
      @(posedge clk); #1;
      chk($sformatf("gpio_out[%08h]", ins), gpio_out, m_gpio);
   endtask

   task automatic reset_step(input logic [31:0] ins);
      rst = 1'b0;
      instruction_EX = ins;
      gpio_in = $urandom;
      @(posedge clk); #1;
      model_reset();
      chk("reset_gpio", gpio_out, 32'd0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] fns [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12,
                               6'h18, 6'h19};
      logic [5:0] nops [5] = '{6'h3f, 6'h01, 6'h02, 6'h04, 6'h30};
      logic [4:0] rs, rt, rd, sh;
      logic [15:0] imm;
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      sh  = 5'($urandom_range(0, 31));
      imm = 16'($urandom);
      case ($urandom_range(0, 9))
         0, 1:    return {6'h2b, rs, rt, imm};
         2, 3, 4: return {6'h00, rs, rt, rd, sh, fns[$urandom_range(0, 16)]};
         5, 6:    return {6'(6'h08 + $urandom_range(0, 7)), rs, rt, imm};
         7:       return {6'h23, rs, rt, imm};
         8:       return {nops[$urandom_range(0, 4)], rs, rt, imm};
         default: return {6'h00, rs, rt, rd, sh, 6'($urandom_range(0, 63))};
      endcase
   endfunction

   initial begin
      rst = 1'b0;
      instruction_EX = '0;
      gpio_in = '0;
      model_reset();

      reset_step($urandom);
      reset_step($urandom);
      rst = 1'b1;
      step(32'hAC010000, $urandom); chk("rst_sw1", gpio_out, 32'h0);

      step(32'h20010005, $urandom);
      step(32'h2002FFFD, $urandom);
      step(32'h00221820, $urandom);
      step(32'hAC030000, $urandom); chk("fwd_add", gpio_out, 32'h00000002);

      step(32'h8C040000, 32'hDEADBEEF);
      step(32'hAC040000, $urandom); chk("gpio_in", gpio_out, 32'hDEADBEEF);

      step(32'h3C010001, $urandom);
      step(32'h3C020001, $urandom);
      step(32'h00220018, $urandom);
      step(32'h00002810, $urandom);
      step(32'hAC050000, $urandom); chk("mfhi", gpio_out, 32'h00000001);
      step(32'h00003012, $urandom);
      step(32'hAC060000, $urandom); chk("mflo", gpio_out, 32'h00000000);

      step(32'h2001FFF8, $urandom);
      step(32'h00013843, $urandom);
      step(32'hAC070000, $urandom); chk("sra", gpio_out, 32'hFFFFFFFC);
      step(32'h00013842, $urandom);
      step(32'hAC070000, $urandom); chk("srl", gpio_out, 32'h7FFFFFFC);
      step(32'h0020402A, $urandom);
      step(32'hAC080000, $urandom); chk("slt", gpio_out, 32'h00000001);
      step(32'h0020402B, $urandom);
      step(32'hAC080000, $urandom); chk("sltu", gpio_out, 32'h00000000);

      step(32'h20000007, $urandom);
      step(32'hAC000000, $urandom); chk("r0_write", gpio_out, 32'h0);
      step(32'hFC21FFFF, $urandom);
      step(32'h0022183F, $urandom);
      step(32'hAC010000, $urandom); chk("nop_r1", gpio_out, 32'hFFFFFFF8);
      step(32'hAC030000, $urandom); chk("nop_r3", gpio_out, 32'h00000002);

      step(32'h20010009, $urandom);
      reset_step(32'h20010009);
      rst = 1'b1;
      step(32'hAC010000, $urandom); chk("rst_drop_wb", gpio_out, 32'h0);

      for (int i = 0; i < 1500; i++) step(rand_instr(), $urandom);
      for (int r = 1; r < 8; r++) step({6'h2b, 5'd0, 5'(r), 16'h0}, $urandom);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
